// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types and helpers.
//   NumDigits    : significand digit count.
//   ExpW         : width of the exponent (decimal point position) field.
//   num_t        : sign, error flag, exponent, BCD significand (digit 0 in bits 3:0).
//   bcd2segments : BCD digit to 7-segment pattern, bit6 = a (top) ... bit0 = g (middle).
//                  Codes above 9 show the 9 pattern.
package calc_pkg;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned ExpW      = $clog2(NumDigits);

  typedef struct packed {
    logic                   sign;
    logic                   error;
    logic [ExpW-1:0]        exponent;
    logic [4*NumDigits-1:0] significand;
  } num_t;

  function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      default: seg = 7'b1111011;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_display_scan.sv
// calc_display_scan: time-multiplexes a calc_pkg::num_t onto a NumDigits-digit
// common-segment 7-segment display with blanking gaps between digits.
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   num_i        value to display
//   num_valid_i  single-cycle strobe, captures num_i (applied at next frame wrap)
//   digit_sel_o  one-hot digit enable, bit 0 = rightmost digit, 0 during the gap
//   segments_o   segment pattern for the enabled digit (bit6 = top ... bit0 = middle)
//   dp_o         decimal point for the enabled digit
//   minus_o      static minus annunciator
//   error_o      static error annunciator
//   frame_o      one-cycle pulse at each frame wrap
module calc_display_scan #(
  parameter int unsigned NumDigits  = calc_pkg::NumDigits,
  parameter int unsigned RefreshDiv = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  calc_pkg::num_t        num_i,
  input  logic                  num_valid_i,
  output logic [NumDigits-1:0]  digit_sel_o,
  output logic [6:0]            segments_o,
  output logic                  dp_o,
  output logic                  minus_o,
  output logic                  error_o,
  output logic                  frame_o
);

  localparam int unsigned CntW = (RefreshDiv > 1) ? $clog2(RefreshDiv) : 1;
  localparam int unsigned IdxW = calc_pkg::ExpW;

  logic [CntW-1:0]      cnt;
  logic [IdxW-1:0]      idx;
  calc_pkg::num_t       active;
  calc_pkg::num_t       pending;
  logic                 pend_flag;

  logic                 slot_wrap;
  logic                 frame_wrap;

  logic [NumDigits-1:0] sel_d;
  logic [6:0]           seg_d;
  logic                 dp_d;
  logic                 minus_d;
  logic                 error_d;
  logic [3:0]           cur_digit;
  logic                 upper_nz;

  assign slot_wrap  = (cnt == CntW'(RefreshDiv - 1));
  assign frame_wrap = slot_wrap && (idx == IdxW'(NumDigits - 1));

  // Scan position and double-buffered value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      idx       <= '0;
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (slot_wrap) begin
        cnt <= '0;
        idx <= frame_wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A strobe landing on the wrap edge bypasses the pending stage so it
      // shows in the frame that starts right now.
      if (frame_wrap) begin
        if (num_valid_i) begin
          active    <= num_i;
          pend_flag <= 1'b0;
        end else if (pend_flag) begin
          active    <= pending;
          pend_flag <= 1'b0;
        end
      end else if (num_valid_i) begin
        pending   <= num_i;
        pend_flag <= 1'b1;
      end
    end
  end

  // Pattern for the digit at the current index, from the active value.
  always_comb begin
    cur_digit = active.significand[idx*4 +: 4];

    // Any nonzero digit at or above the current index keeps it lit.
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < NumDigits; j++) begin
      if ((j >= 32'(idx)) && (active.significand[j*4 +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end

    sel_d = '0;
    if (cnt != '0) begin
      sel_d = {{(NumDigits-1){1'b0}}, 1'b1} << idx;
    end

    seg_d = '0;
    dp_d  = 1'b0;
    if (active.error) begin
      if (idx == '0) begin
        seg_d = 7'b1001111;
      end
    end else begin
      if ((idx <= active.exponent) || upper_nz) begin
        seg_d = calc_pkg::bcd2segments(cur_digit);
      end
      dp_d = (idx == active.exponent) && (active.exponent != '0);
    end

    minus_d = active.sign & ~active.error;
    error_d = active.error;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_sel_o <= '0;
      segments_o  <= '0;
      dp_o        <= 1'b0;
      minus_o     <= 1'b0;
      error_o     <= 1'b0;
      frame_o     <= 1'b0;
    end else begin
      digit_sel_o <= sel_d;
      segments_o  <= seg_d;
      dp_o        <= dp_d;
      minus_o     <= minus_d;
      error_o     <= error_d;
      frame_o     <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_calc_display_scan.sv
// tb_calc_display_scan: directed and randomized stimulus for calc_display_scan
// (RefreshDiv = 4), checked every cycle against a frame-level reference model.
module tb_calc_display_scan;
  import calc_pkg::*;

  localparam int unsigned R  = 4;
  localparam int unsigned N  = calc_pkg::NumDigits;
  localparam int unsigned FR = N * R;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  num_t         num = '0;
  logic         num_valid = 1'b0;
  logic [N-1:0] digit_sel;
  logic [6:0]   segments;
  logic         dp;
  logic         minus;
  logic         error;
  logic         frame;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model state: edges since reset release and the two buffers.
  int unsigned tick = 0;
  num_t        m_act  = '0;
  num_t        m_pend = '0;
  bit          m_flag = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  calc_display_scan #(.NumDigits(N), .RefreshDiv(R)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .num_i      (num),
    .num_valid_i(num_valid),
    .digit_sel_o(digit_sel),
    .segments_o (segments),
    .dp_o       (dp),
    .minus_o    (minus),
    .error_o    (error),
    .frame_o    (frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, expv, tick);
  endtask

  function automatic num_t mk(input bit s, input bit e, input int unsigned x,
                              input logic [31:0] sig);
    num_t n;
    n.sign        = s;
    n.error       = e;
    n.exponent    = ExpW'(x);
    n.significand = sig;
    return n;
  endfunction

  // What digit d of value n should look like.
  task automatic ref_digit(input num_t n, input int unsigned d,
                           output logic [6:0] s, output logic p);
    int msd;
    int unsigned top;
    int unsigned nib;
    s = '0;
    p = 1'b0;
    if (n.error) begin
      if (d == 0) s = 7'b1001111;
    end else begin
      msd = -1;
      for (int i = 0; i < int'(N); i++)
        if (n.significand[i*4 +: 4] != 4'd0) msd = i;
      top = (msd > int'(n.exponent)) ? int'(msd) : int'(n.exponent);
      nib = n.significand[d*4 +: 4];
      if (d <= top) s = seg_tab[(nib > 9) ? 9 : nib];
      p = (d == int'(n.exponent)) && (n.exponent != 0);
    end
  endtask

  // One clock: drive inputs, check outputs after the edge, advance the model.
  task automatic cycle(input bit v, input num_t n);
    int unsigned p, slot, dig;
    logic [6:0] es;
    logic       ep;
    num_valid = v;
    num       = n;
    @(posedge clk);
    #1;
    num_valid = 1'b0;
    p    = tick % FR;
    slot = p % R;
    dig  = p / R;
    ref_digit(m_act, dig, es, ep);
    chk("digit_sel", 32'(digit_sel), (slot == 0) ? 32'd0 : (32'd1 << dig));
    chk("segments",  32'(segments), 32'(es));
    chk("dp",        32'(dp), 32'(ep));
    chk("minus",     32'(minus), 32'(m_act.sign & ~m_act.error));
    chk("error",     32'(error), 32'(m_act.error));
    chk("frame",     32'(frame), 32'(p == FR - 1));
    if (p == FR - 1) begin
      if (v) begin
        m_act  = n;
        m_flag = 1'b0;
      end else if (m_flag) begin
        m_act  = m_pend;
        m_flag = 1'b0;
      end
    end else if (v) begin
      m_pend = n;
      m_flag = 1'b1;
    end
    tick++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"},   32'(digit_sel), 32'd0);
    chk({tag, "_seg"},   32'(segments), 32'd0);
    chk({tag, "_dp"},    32'(dp), 32'd0);
    chk({tag, "_minus"}, 32'(minus), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    @(negedge clk);
    rst    = 1'b0;
    tick   = 0;
    m_act  = '0;
    m_pend = '0;
    m_flag = 1'b0;
    chk_zero({tag, "_rel"});
  endtask

  // Step idle cycles until the last edge was at frame position pos.
  task automatic run_to(input int unsigned pos);
    int unsigned guard = 0;
    do begin
      cycle(1'b0, '0);
      guard++;
    end while ((((tick - 1) % FR) != pos) && (guard < 2 * FR));
    chk("run_to_bound", 32'(guard < 2 * FR), 32'd1);
  endtask

  function automatic num_t rnd_num();
    num_t n;
    int unsigned k;
    n.sign     = 1'($urandom_range(0, 1));
    n.error    = ($urandom_range(0, 9) == 0);
    n.exponent = ExpW'($urandom_range(0, N - 1));
    k = $urandom_range(0, N);
    for (int unsigned i = 0; i < N; i++)
      n.significand[i*4 +: 4] = (i < k) ? 4'($urandom_range(0, 11)) : 4'd0;
    return n;
  endfunction

  initial begin
    num_t na, nb, nc;

    // Reset state and idle scan of the zero value.
    do_reset("reset");
    run_to(1);
    chk("idle_d0_sel", 32'(digit_sel), 32'h01);
    chk("idle_d0_seg", 32'(segments), 32'(7'b1111110));
    run_to(R + 1);
    chk("idle_d1_seg", 32'(segments), 32'd0);
    run_to(FR - 1);
    chk("idle_frame", 32'(frame), 32'd1);

    // 12345 with decimal point at digit 2.
    run_to(6);
    cycle(1'b1, mk(1'b0, 1'b0, 2, 32'h00012345));
    run_to(FR - 1);
    run_to(1);
    chk("v1_d0", 32'(segments), 32'(7'b1011011));
    chk("v1_dp0", 32'(dp), 32'd0);
    run_to(2 * R + 1);
    chk("v1_d2", 32'(segments), 32'(7'b1111001));
    chk("v1_dp2", 32'(dp), 32'd1);
    run_to(4 * R + 1);
    chk("v1_d4", 32'(segments), 32'(7'b0110000));
    run_to(5 * R + 1);
    chk("v1_d5", 32'(segments), 32'd0);
    chk("v1_minus", 32'(minus), 32'd0);

    // -7, exponent 0.
    cycle(1'b1, mk(1'b1, 1'b0, 0, 32'h00000007));
    run_to(FR - 1);
    run_to(1);
    chk("v2_d0", 32'(segments), 32'(7'b1110000));
    chk("v2_minus", 32'(minus), 32'd1);
    chk("v2_dp", 32'(dp), 32'd0);

    // Error loaded mid-frame: old value holds until the wrap.
    run_to(3 * R + 1);
    cycle(1'b1, mk(1'b1, 1'b1, 3, 32'h00000042));
    run_to(7 * R + 1);
    chk("err_old_d7", 32'(segments), 32'd0);
    chk("err_old_minus", 32'(minus), 32'd1);
    chk("err_old_error", 32'(error), 32'd0);
    run_to(1);
    chk("err_d0", 32'(segments), 32'(7'b1001111));
    chk("err_error", 32'(error), 32'd1);
    chk("err_minus", 32'(minus), 32'd0);
    run_to(R + 1);
    chk("err_d1", 32'(segments), 32'd0);

    // Two strobes in one frame, then a strobe on the wrap edge.
    na = mk(1'b0, 1'b0, 0, 32'h11111111);
    nb = mk(1'b0, 1'b0, 1, 32'h00000006);
    nc = mk(1'b1, 1'b0, 0, 32'h00000009);
    cycle(1'b1, na);
    run_to(9);
    cycle(1'b1, nb);
    run_to(FR - 1);
    run_to(1);
    chk("last_wins_d0", 32'(segments), 32'(7'b1011111));
    run_to(R + 1);
    chk("last_wins_d1", 32'(segments), 32'(7'b1111110));
    chk("last_wins_dp1", 32'(dp), 32'd1);
    run_to(FR - 2);
    cycle(1'b1, nc);
    chk("wrap_strobe_frame", 32'(frame), 32'd1);
    run_to(1);
    chk("wrap_strobe_d0", 32'(segments), 32'(7'b1111011));
    chk("wrap_strobe_minus", 32'(minus), 32'd1);

    // Mid-frame reset discards a pending value.
    run_to(5 * R + 1);
    cycle(1'b1, mk(1'b0, 1'b0, 0, 32'h00000088));
    do_reset("mid_reset");
    run_to(1);
    chk("post_reset_d0", 32'(segments), 32'(7'b1111110));
    run_to(FR - 1);
    run_to(FR - 1);
    run_to(1);
    chk("post_reset_d0_late", 32'(segments), 32'(7'b1111110));

    // Randomized traffic, including strobes on the wrap edge.
    for (int i = 0; i < 1200; i++)
      cycle($urandom_range(0, 7) == 0, rnd_num());
    for (int k = 0; k < 12; k++) begin
      run_to(FR - 2);
      cycle(1'b1, rnd_num());
      for (int i = 0; i < int'($urandom_range(1, 40)); i++)
        cycle($urandom_range(0, 5) == 0, rnd_num());
    end
    do_reset("rand_reset");
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 7) == 0, rnd_num());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
